// File: rtl/ocm_s2_arb_pkg.sv
// Shared constants and the round-robin pick function for the s2 arbiter.
package ocm_s2_arb_pkg;
  localparam int AW_DEF  = 14;
  localparam int DW_DEF  = 64;
  localparam int GCNT_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // One-hot grant: first valid index found scanning ptr, ptr+1, ... mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/ocm_s2_rd_tag_pipe.sv
// Read-owner tag shift register aligned to the s2 read latency, plus the
// registered response stage that returns readdata to the owning requester.
module ocm_s2_rd_tag_pipe #(
  parameter int NREQ       = 2,
  parameter int DW         = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] tag_in,
  input  logic [DW-1:0]   rd_data,
  output logic [NREQ-1:0] rsp_valid,
  output logic [DW-1:0]   rsp_data
);
  // Stage k holds the owner of the read whose data lands k cycles after chipselect.
  logic [RD_LATENCY:0][NREQ-1:0] tag_q, tag_d;
  logic [NREQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]                 rsp_data_q, rsp_data_d;

  // Shift tags; capture readdata when the last stage names an owner, else hold.
  always_comb begin
    tag_d[0] = tag_in;
    for (int k = 1; k <= RD_LATENCY; k++) tag_d[k] = tag_q[k-1];
    rsp_valid_d = tag_q[RD_LATENCY];
    rsp_data_d  = (|tag_q[RD_LATENCY]) ? rd_data : rsp_data_q;
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: rtl/ocm_s2_arbiter.sv
// Round-robin arbiter for the on-chip memory s2 port. Registered s2 pins,
// one command per cycle, fixed-latency read return to the issuing requester.
// Optional per-requester grant counters: define OCM_S2_ARB_GRANT_CNT_EN.
module ocm_s2_arbiter
  import ocm_s2_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW/8-1:0] req_be,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [AW-1:0]        onchip_memory_s2_address,
  output logic                 onchip_memory_s2_chipselect,
  output logic                 onchip_memory_s2_clken,
  output logic                 onchip_memory_s2_write,
  output logic [DW-1:0]        onchip_memory_s2_writedata,
  output logic [DW/8-1:0]      onchip_memory_s2_byteenable,
  input  logic [DW-1:0]        onchip_memory_s2_readdata
`ifdef OCM_S2_ARB_GRANT_CNT_EN
  ,
  input  logic                 grant_cnt_clr,
  output logic [NREQ*GCNT_W-1:0] grant_cnt
`endif
);
  localparam int BW = DW / 8;

  logic [PTR_W-1:0]   ptr_q, ptr_d, gidx;
  logic [MAX_REQ-1:0] valid_ext, gnt_ext;
  logic [NREQ-1:0]    gnt, rd_tag;
  logic               accept;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [BW-1:0]      be_q, be_d;
  logic               cs_q, cs_d, wr_q, wr_d, clken_q;

  // Combinational grant; held off during reset so nothing is accepted then.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    gnt_ext               = rr_pick(valid_ext, ptr_q, NREQ);
    gnt                   = reset_reset ? '0 : gnt_ext[NREQ-1:0];
    gidx                  = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gidx = PTR_W'(i);
  end

  generate
    if (NREQ < MAX_REQ) begin : g_pad
      logic unused_gnt;
      assign unused_gnt = ^gnt_ext[MAX_REQ-1:NREQ];
    end
  endgenerate

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign rd_tag    = gnt & ~req_write;

  // Next s2 command and pointer; address/data/be hold when idle.
  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cs_d    = accept;
    wr_d    = 1'b0;
    if (accept) begin
      wr_d    = req_write[gidx];
      addr_d  = req_addr[int'(gidx)*AW +: AW];
      wdata_d = req_wdata[int'(gidx)*DW +: DW];
      be_d    = req_be[int'(gidx)*BW +: BW];
      ptr_d   = (int'(gidx) == NREQ-1) ? '0 : gidx + 3'd1;
    end
  end

  // s2 pin and pointer registers; reset cancels any command on the pins.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      clken_q <= 1'b1;
    end
  end

  assign onchip_memory_s2_address     = addr_q;
  assign onchip_memory_s2_chipselect  = cs_q;
  assign onchip_memory_s2_clken       = clken_q;
  assign onchip_memory_s2_write       = wr_q;
  assign onchip_memory_s2_writedata   = wdata_q;
  assign onchip_memory_s2_byteenable  = be_q;

  ocm_s2_rd_tag_pipe #(.NREQ(NREQ), .DW(DW), .RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .tag_in    (rd_tag),
    .rd_data   (onchip_memory_s2_readdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

`ifdef OCM_S2_ARB_GRANT_CNT_EN
  logic [NREQ-1:0][GCNT_W-1:0] gcnt_q, gcnt_d;

  // Saturating per-requester grant counters; clear beats increment.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (grant_cnt_clr)                    gcnt_d[i] = '0;
      else if (gnt[i] && gcnt_q[i] != '1)   gcnt_d[i] = gcnt_q[i] + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) gcnt_q <= '0;
    else             gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`endif
endmodule
